// File: rtl/rgb_to_hsv_stream.sv
// Streaming RGB-to-HSV converter: one pixel in flight, H and S quotients come
// from one shared restoring divider, results held under output backpressure.
module rgb_to_hsv_stream #(
  parameter int PIX_W     = 8,
  parameter int FRAC_BITS = 16,
  parameter int HUE_MODE  = 0,
  parameter int S_MAX     = (1 << PIX_W) - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] r,
  input  logic [PIX_W-1:0] g,
  input  logic [PIX_W-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [8:0]       h,
  output logic [PIX_W-1:0] s,
  output logic [PIX_W-1:0] v,
  output logic             busy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; out_valid and h/s/v never change while out_ready is low.
  localparam int DIV_CYC = FRAC_BITS + 1;
  localparam int CW      = $clog2(DIV_CYC);
  localparam int IW      = PIX_W + FRAC_BITS + 10;
  localparam int H_WRAP  = (HUE_MODE == 0) ? 180 : 360;

  typedef enum logic [2:0] {
    IDLE, LOAD, GREY, DIV_H, DIV_S, SCALE, OUT
  } state_t;

  state_t state;

  logic [PIX_W-1:0] r_q, g_q, b_q;
  logic [PIX_W-1:0] max_q, delta_q;
  logic [8:0]       off_q;
  logic             neg_q;
  logic [FRAC_BITS:0] f_q;

  logic [PIX_W:0]     div_rem;
  logic [PIX_W-1:0]   div_den;
  logic [FRAC_BITS:0] div_q;
  logic [CW-1:0]      div_cnt;

  // Pixel analysis on the captured channels
  logic [PIX_W-1:0]        mx, mn, delta;
  logic signed [PIX_W:0]   num;
  logic [PIX_W:0]          num_abs;
  logic [8:0]              off;

  always_comb begin
    mx  = b_q;
    num = $signed({1'b0, r_q}) - $signed({1'b0, g_q});
    off = 9'd240;
    if (r_q >= g_q && r_q >= b_q) begin
      mx  = r_q;
      num = $signed({1'b0, g_q}) - $signed({1'b0, b_q});
      off = 9'd0;
    end else if (g_q >= b_q) begin
      mx  = g_q;
      num = $signed({1'b0, b_q}) - $signed({1'b0, r_q});
      off = 9'd120;
    end
    mn      = (r_q < g_q) ? r_q : g_q;
    mn      = (mn < b_q) ? mn : b_q;
    delta   = mx - mn;
    num_abs = num[PIX_W] ? $unsigned(-num) : $unsigned(num);
  end

  // One restoring step: the dividend never exceeds the divisor, so the
  // remainder fits in PIX_W+1 bits and the first step yields the 2^0 bit.
  logic               ge;
  logic [PIX_W:0]     rem_sub, rem_next;
  logic [FRAC_BITS:0] q_next;
  logic               div_last;

  always_comb begin
    ge       = (div_rem >= {1'b0, div_den});
    rem_sub  = ge ? (div_rem - {1'b0, div_den}) : div_rem;
    rem_next = rem_sub << 1;
    q_next   = {div_q[FRAC_BITS-1:0], ge};
    div_last = (div_cnt == CW'(DIV_CYC - 1));
  end

  // Hue and saturation scaling; div_q holds the S quotient while in SCALE
  logic [IW-1:0]        off_fx, sixty_f, hue_u, h_full, s_full;
  logic signed [IW-1:0] hue_fx;
  logic [8:0]           h_val;
  logic [PIX_W-1:0]     s_val;

  always_comb begin
    off_fx  = IW'(off_q) << FRAC_BITS;
    sixty_f = IW'(f_q) * IW'(60);
    hue_fx  = neg_q ? $signed(off_fx - sixty_f) : $signed(off_fx + sixty_f);
    hue_u   = (hue_fx < 0) ? ($unsigned(hue_fx) + (IW'(360) << FRAC_BITS))
                           : $unsigned(hue_fx);
    if (HUE_MODE == 0)
      h_full = (hue_u + (IW'(1) << FRAC_BITS)) >> (FRAC_BITS + 1);
    else
      h_full = (hue_u + (IW'(1) << (FRAC_BITS - 1))) >> FRAC_BITS;
    h_val  = (h_full == IW'(H_WRAP)) ? 9'd0 : h_full[8:0];
    s_full = (IW'(S_MAX) * IW'(div_q) + (IW'(1) << (FRAC_BITS - 1))) >> FRAC_BITS;
    s_val  = (s_full > IW'(S_MAX)) ? PIX_W'(S_MAX) : s_full[PIX_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      h         <= '0;
      s         <= '0;
      v         <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      max_q     <= '0;
      delta_q   <= '0;
      off_q     <= '0;
      neg_q     <= 1'b0;
      f_q       <= '0;
      div_rem   <= '0;
      div_den   <= '0;
      div_q     <= '0;
      div_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_q      <= r;
            g_q      <= g;
            b_q      <= b;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          max_q   <= mx;
          delta_q <= delta;
          off_q   <= off;
          neg_q   <= num[PIX_W];
          div_rem <= num_abs;
          div_den <= delta;
          div_q   <= '0;
          div_cnt <= '0;
          state   <= (delta == '0) ? GREY : DIV_H;
        end
        GREY: begin
          h         <= '0;
          s         <= '0;
          v         <= max_q;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        DIV_H: begin
          div_rem <= rem_next;
          div_q   <= q_next;
          div_cnt <= div_cnt + CW'(1);
          if (div_last) begin
            f_q     <= q_next;
            div_rem <= {1'b0, delta_q};
            div_den <= max_q;
            div_q   <= '0;
            div_cnt <= '0;
            state   <= DIV_S;
          end
        end
        DIV_S: begin
          div_rem <= rem_next;
          div_q   <= q_next;
          div_cnt <= div_cnt + CW'(1);
          if (div_last) state <= SCALE;
        end
        SCALE: begin
          h         <= h_val;
          s         <= s_val;
          v         <= max_q;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_to_hsv_stream.sv
// Directed bench for rgb_to_hsv_stream: two instances (hue 0..179 and 0..359)
// share stimulus; results go through an expected-value queue.
module tb_rgb_to_hsv_stream;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, out_ready;
  logic [7:0] r, g, b;

  logic       in_ready0, out_valid0, busy0;
  logic [8:0] h0;
  logic [7:0] s0, v0;
  logic       in_ready1, out_valid1, busy1;
  logic [8:0] h1;
  logic [7:0] s1, v1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  rgb_to_hsv_stream #(.PIX_W(8), .FRAC_BITS(16), .HUE_MODE(0)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .r(r), .g(g), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
    .h(h0), .s(s0), .v(v0), .busy(busy0)
  );

  rgb_to_hsv_stream #(.PIX_W(8), .FRAC_BITS(16), .HUE_MODE(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .r(r), .g(g), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
    .h(h1), .s(s1), .v(v1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send_pixel(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    int t = 0;
    @(negedge clk);
    while (!in_ready0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("send_timeout", in_ready0, 1);
    r = rr; g = gg; b = bb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    r = 8'($urandom_range(0, 255));
    g = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
  endtask

  // latency counts the accept cycle itself
  task automatic wait_out(input string tag, input int exp_lat);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check({tag, "_busy"}, {busy0, in_ready0, busy1, in_ready1}, 4'b1010);
    end while (!out_valid0 && lat < 100);
    if (!out_valid0) check({tag, "_timeout"}, out_valid0, 1);
    else check({tag, "_latency"}, lat, exp_lat);
  endtask

  task automatic expect_pix(input logic [8:0] eh0, input logic [8:0] eh1,
                            input logic [7:0] es, input logic [7:0] ev);
    exp_q.push_back({eh0, eh1, es, ev});
  endtask

  // scoreboard
  task automatic check_result(input string tag);
    logic [33:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, exp_q.size(), 1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_h"}, h0, e[33:25]);
    check({tag, "_h360"}, h1, e[24:16]);
    check({tag, "_s"}, s0, e[15:8]);
    check({tag, "_v"}, v0, e[7:0]);
    check({tag, "_sv360"}, {s1, v1, out_valid1}, {e[15:8], e[7:0], 1'b1});
  endtask

  task automatic handshake(input string tag);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_release"}, {in_ready0, out_valid0, busy0}, 3'b100);
  endtask

  task automatic run_pixel(input string tag, input logic [7:0] rr, input logic [7:0] gg,
                           input logic [7:0] bb, input logic [8:0] eh0, input logic [8:0] eh1,
                           input logic [7:0] es, input logic [7:0] ev, input int lat);
    expect_pix(eh0, eh1, es, ev);
    send_pixel(rr, gg, bb);
    wait_out(tag, lat);
    check_result(tag);
    handshake(tag);
  endtask

  logic [24:0] held;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    r = '0; g = '0; b = '0;
    #12;
    check("reset_state", {in_ready0, out_valid0, busy0, h0, s0, v0},
          {1'b1, 1'b0, 1'b0, 9'd0, 8'd0, 8'd0});
    check("reset_state_360", {in_ready1, out_valid1, busy1, h1}, {3'b100, 9'd0});
    @(negedge clk);
    reset = 1'b0;

    // primaries
    run_pixel("red",   8'd255, 8'd0,   8'd0,   9'd0,   9'd0,   8'd255, 8'd255, 37);
    run_pixel("green", 8'd0,   8'd255, 8'd0,   9'd60,  9'd120, 8'd255, 8'd255, 37);
    run_pixel("blue",  8'd0,   8'd0,   8'd255, 9'd120, 9'd240, 8'd255, 8'd255, 37);
    // grey and black
    run_pixel("grey",  8'd128, 8'd128, 8'd128, 9'd0,   9'd0,   8'd0,   8'd128, 3);
    run_pixel("black", 8'd0,   8'd0,   8'd0,   9'd0,   9'd0,   8'd0,   8'd0,   3);
    // wrap and rounding
    run_pixel("wrap",  8'd255, 8'd0,   8'd128, 9'd165, 9'd330, 8'd255, 8'd255, 37);
    run_pixel("brown", 8'd100, 8'd50,  8'd25,  9'd10,  9'd20,  8'd191, 8'd100, 37);
    // ties
    run_pixel("tie_rg", 8'd200, 8'd200, 8'd0,   9'd30, 9'd60,  8'd255, 8'd200, 37);
    run_pixel("tie_gb", 8'd0,   8'd200, 8'd200, 9'd90, 9'd180, 8'd255, 8'd200, 37);

    // backpressure at OUT
    out_ready = 1'b0;
    expect_pix(9'd165, 9'd330, 8'd255, 8'd255);
    send_pixel(8'd255, 8'd0, 8'd128);
    wait_out("bp", 37);
    held = {h0, s0, v0};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_hold", {out_valid0, in_ready0, busy0, h0, s0, v0}, {3'b101, held});
    end
    check_result("bp");
    out_ready = 1'b1;
    handshake("bp");
    run_pixel("after_bp", 8'd0, 8'd200, 8'd200, 9'd90, 9'd180, 8'd255, 8'd200, 37);

    // asynchronous reset while the saturation division is running
    send_pixel(8'd255, 8'd0, 8'd128);
    repeat (25) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async", {in_ready0, out_valid0, busy0, h0, s0, v0},
          {1'b1, 1'b0, 1'b0, 9'd0, 8'd0, 8'd0});
    check("rst_async_360", {in_ready1, out_valid1, busy1, h1}, {3'b100, 9'd0});
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check("rst_no_stale", {out_valid0, busy0, out_valid1}, 3'b000);
    end
    run_pixel("post_rst", 8'd100, 8'd50, 8'd25, 9'd10, 9'd20, 8'd191, 8'd100, 37);

    check("sb_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_to_hsv_stream.md
Name: rgb_to_hsv_stream

Overview:
Streaming, parametrised RGB-to-HSV converter for the edge_vision pixel path. It accepts one integer RGB pixel through a valid/ready handshake. It computes integer H, S and V with a single shared shift-subtract divider, so a full S division is performed, not a stub. H range is selectable: OpenCV 0..179 or degrees 0..359. Output is a valid/ready stream with hold-under-backpressure, sitting between the frame reader and the colour-threshold stage.

Parameters:
PIX_W, 8, bit width of each input channel and of V and S outputs
FRAC_BITS, 16, fractional bits of internal fixed-point quotients; divider runs DIV_CYC = FRAC_BITS+1 cycles
HUE_MODE, 0, 0 = H in 0..179 (deg/2), 1 = H in 0..359
S_MAX, (1<<PIX_W)-1, full-scale saturation value

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept a pixel
r  in  PIX_W  red, unsigned integer
g  in  PIX_W  green
b  in  PIX_W  blue
out_valid  out  1  h/s/v valid
out_ready  in  1  downstream accepts
h  out  9  hue, integer
s  out  PIX_W  saturation, integer 0..S_MAX
v  out  PIX_W  value, integer = max(r,g,b)
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, any state, including mid-division): state=IDLE; in_ready=1; out_valid=0; h=s=v=0; busy=0; divider cleared. No partial result is ever emitted.
- States: IDLE -> LOAD -> (GREY | DIV_H) ; DIV_H -> DIV_S -> SCALE -> OUT ; GREY -> OUT ; OUT -> IDLE.
- IDLE: in_ready=1. Handshake when in_valid&in_ready; r,g,b are captured into internal registers. Inputs are don't-care afterwards.
- LOAD, 1 cycle:
  - max, min, delta = max-min.
  - Dominant channel priority: r if r>=g and r>=b; else g if g>=b; else b.
  - Signed numerator N and offset: r: N=g-b, offset 0; g: N=b-r, offset 120; b: N=r-g, offset 240.
  - delta==0 (includes black) goes to GREY; otherwise DIV_H.
- GREY, 1 cycle: h=0, s=0, v=max.
- DIV_H, DIV_CYC cycles: unsigned restoring division f = floor((|N|<<FRAC_BITS)/delta), f<=1.0.
- DIV_S, DIV_CYC cycles: q = floor((delta<<FRAC_BITS)/max).
- SCALE, 1 cycle:
  - hdeg = offset +/- 60*f (sign of N). If hdeg<0, add 360.
  - HUE_MODE 0: h = round-half-up(hdeg/2); result 180 maps to 0.
  - HUE_MODE 1: h = round-half-up(hdeg); result 360 maps to 0.
  - s = round-half-up(S_MAX*q), clamped to S_MAX. v = max.
  - Intermediate width: PIX_W+FRAC_BITS+10 bits, no overflow for any input.
- OUT: out_valid=1. h/s/v are held stable until out_ready. On out_valid&out_ready, go to IDLE next cycle with out_valid=0.
- in_ready=0 in all states except IDLE. There is no overlap between pixels.
- Latency from accept edge to out_valid:
  - chromatic: 2*DIV_CYC+3 cycles (37 at defaults)
  - grey: 3 cycles
- Minimum initiation interval = latency+1 with out_ready held high.
- out_ready is ignored outside OUT. in_valid is ignored outside IDLE.

Test Plan:
Defaults (PIX_W=8, FRAC_BITS=16, HUE_MODE=0):
1. Primaries:
   - (255,0,0) -> h0 s255 v255
   - (0,255,0) -> h60 s255 v255
   - (0,0,255) -> h120 s255 v255
   - out_valid exactly 37 cycles after each accept.
2. Grey and black:
   - (128,128,128) -> h0 s0 v128, out_valid 3 cycles after accept
   - (0,0,0) -> h0 s0 v0
3. Wrap and rounding:
   - (255,0,128) -> h165 s255 v255
   - (100,50,25) -> h10 s191 v100
   - Rerun with HUE_MODE=1 -> h330 and h20.
4. Ties:
   - (200,200,0) -> red priority, h30 s255 v200
   - (0,200,200) -> green priority, h90 s255 v200
5. Backpressure: hold out_ready=0 for 20 cycles at OUT.
   - out_valid stays 1, h/s/v constant, in_ready stays 0.
   - Release, then send a new pixel.
   - Next result is correct and in_ready returns 1 one cycle after the out handshake.
6. Reset mid-DIV_S: assert reset asynchronously between clock edges.
   - Immediately: out_valid=0, h=s=v=0, busy=0, in_ready=1.
   - No stale output afterwards.
   - Next pixel (100,50,25) yields h10 s191 v100.
